// File: rtl/riscv_bp_pkg.sv
// Shared types for the branch-predictor update path.
// Holds the predictor geometry, the update record and the controller state encoding.
// No ports; imported by riscv_bp_upd_fifo and riscv_bp_update_ctrl.
package riscv_bp_pkg;

  localparam int BP_INDEX_WIDTH = 8;
  localparam int BP_TABLE_SIZE  = 256;

  typedef struct packed {
    logic [63:0] pc;
    logic        taken;
    logic [63:0] target;
  } bp_update_t;

  typedef enum logic {
    BPC_IDLE,
    BPC_FLUSH
  } bp_ctrl_state_e;

endpackage

// File: rtl/riscv_bp_upd_fifo.sv
// Update FIFO: up to NUM_PUSH writes per cycle (packed in ascending slot order), one read per cycle.
// Latency: a pushed entry is visible at head the cycle after the push; head is combinational.
// Backpressure: none internally; the caller must not push more than free_slots. clear empties it synchronously.
// Ports: clk, rst_n, clear, push[NUM_PUSH], push_data[NUM_PUSH], pop -> head, empty, free_slots.
module riscv_bp_upd_fifo
  import riscv_bp_pkg::*;
#(
  parameter  int NUM_PUSH = 2,
  parameter  int DEPTH    = 4,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic [NUM_PUSH-1:0] push,
  input  bp_update_t          push_data [NUM_PUSH],
  input  logic                pop,
  output bp_update_t          head,
  output logic                empty,
  output logic [CNT_W-1:0]    free_slots
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;

  bp_update_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] push_cnt;
  logic [PTR_W-1:0] wr_idx [NUM_PUSH];
  logic             pop_ok;

  // Each active push slot lands right after the active slots below it, so
  // simultaneous pushes keep ascending requester order with no holes.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < NUM_PUSH; i++) begin
      wr_idx[i] = wr_ptr + push_cnt[PTR_W-1:0];
      if (push[i]) push_cnt = push_cnt + CNT_ONE;
    end
  end

  assign empty      = (count == '0);
  assign pop_ok     = pop && !empty;
  assign head       = mem[rd_ptr];
  assign free_slots = CNT_W'(DEPTH) - count;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PUSH; i++) begin
      if (push[i] && !clear) mem[wr_idx[i]] <= push_data[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is plain truncation.
      wr_ptr <= wr_ptr + push_cnt[PTR_W-1:0];
      if (pop_ok) rd_ptr <= rd_ptr + PTR_ONE;
      count  <= count + push_cnt - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/riscv_bp_update_ctrl.sv
// Sequences every write into the branch predictor update port: buffered resolutions and flush-walk clears.
// Latency: handshake in cycle t -> upd_valid in t+2 on an empty queue; a flush walk is 2**INDEX_WIDTH cycles.
// Backpressure: req_ready (same on all bits) drops while flushing, on flush_req, or when fewer than NUM_REQ slots are free.
// Ports: req_valid/req_ready/req_pc/req_taken/req_target (per requester), flush_req/flush_busy,
//        upd_valid/upd_pc/upd_taken/upd_target/upd_clear toward the predictor.
module riscv_bp_update_ctrl
  import riscv_bp_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int INDEX_WIDTH = BP_INDEX_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*64-1:0] req_pc,
  input  logic [NUM_REQ-1:0]    req_taken,
  input  logic [NUM_REQ*64-1:0] req_target,
  input  logic                  flush_req,
  output logic                  flush_busy,
  output logic                  upd_valid,
  output logic [63:0]           upd_pc,
  output logic                  upd_taken,
  output logic [63:0]           upd_target,
  output logic                  upd_clear
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [INDEX_WIDTH:0] IDX_ONE = 1;

  bp_ctrl_state_e       state;
  logic [INDEX_WIDTH:0] idx;
  logic [INDEX_WIDTH:0] idx_inc;
  logic                 last_idx;
  logic                 ready_en;
  logic                 accept;
  logic                 pop;
  logic [NUM_REQ-1:0]   push;
  bp_update_t           push_data [NUM_REQ];
  bp_update_t           fifo_head;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     free_slots;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      push_data[i].pc     = req_pc[64*i +: 64];
      push_data[i].taken  = req_taken[i];
      push_data[i].target = req_target[64*i +: 64];
    end
  end

  // ready_en keeps req_ready low while in reset and until the first clock after release.
  assign accept     = ready_en && (state == BPC_IDLE) && !flush_req &&
                      (free_slots >= CNT_W'(NUM_REQ));
  assign req_ready  = {NUM_REQ{accept}};
  assign push       = req_valid & req_ready;
  assign pop        = (state == BPC_IDLE) && !flush_req && !fifo_empty;
  assign flush_busy = (state == BPC_FLUSH);

  // The walk index has a spare MSB; terminal detection looks only at the low bits.
  assign idx_inc  = idx + IDX_ONE;
  assign last_idx = &idx[INDEX_WIDTH-1:0];

  riscv_bp_upd_fifo #(
    .NUM_PUSH (NUM_REQ),
    .DEPTH    (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (flush_req),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .head       (fifo_head),
    .empty      (fifo_empty),
    .free_slots (free_slots)
  );

  // Outputs are registered: each cycle defaults to an idle output stage, then
  // either loads the FIFO head or the next flush clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BPC_IDLE;
      idx        <= '0;
      ready_en   <= 1'b0;
      upd_valid  <= 1'b0;
      upd_pc     <= '0;
      upd_taken  <= 1'b0;
      upd_target <= '0;
      upd_clear  <= 1'b0;
    end else begin
      ready_en   <= 1'b1;
      upd_valid  <= 1'b0;
      upd_pc     <= '0;
      upd_taken  <= 1'b0;
      upd_target <= '0;
      upd_clear  <= 1'b0;
      if (state == BPC_IDLE) begin
        if (flush_req) begin
          // Queued entries are dropped (FIFO clears); first clear is index 0.
          state     <= BPC_FLUSH;
          idx       <= '0;
          upd_valid <= 1'b1;
          upd_clear <= 1'b1;
        end else if (pop) begin
          upd_valid  <= 1'b1;
          upd_pc     <= fifo_head.pc;
          upd_taken  <= fifo_head.taken;
          upd_target <= fifo_head.target;
        end
      end else begin
        if (flush_req) begin
          // Restart the walk from index 0 with no gap.
          idx       <= '0;
          upd_valid <= 1'b1;
          upd_clear <= 1'b1;
        end else if (last_idx) begin
          state <= BPC_IDLE;
        end else begin
          idx       <= idx_inc;
          upd_valid <= 1'b1;
          upd_clear <= 1'b1;
          upd_pc    <= 64'({idx_inc, 2'b00});
        end
      end
    end
  end

endmodule

// File: tb/tb_riscv_bp_update_ctrl.sv
module tb_riscv_bp_update_ctrl;
  import riscv_bp_pkg::*;

  localparam int NR    = 2;
  localparam int DEPTH = 4;
  localparam int TBL   = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_ready;
  logic [127:0]  req_pc = '0;
  logic [NR-1:0] req_taken = '0;
  logic [127:0]  req_target = '0;
  logic          flush_req = 1'b0;
  logic          flush_busy;
  logic          upd_valid;
  logic [63:0]   upd_pc;
  logic          upd_taken;
  logic [63:0]   upd_target;
  logic          upd_clear;

  always #5 clk = ~clk;

  riscv_bp_update_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_pc     (req_pc),
    .req_taken  (req_taken),
    .req_target (req_target),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .upd_clear  (upd_clear)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  // Queue of pending updates + one presented entry, or a walk position while flushing.
  bp_update_t  m_q[$];
  bp_update_t  m_out = '0;
  bit          m_vld = 0;
  bit          m_flush = 0;
  bit          m_ren = 0;
  int          m_idx = 0;
  logic [63:0] obs_q[$];
  int          clr_cnt = 0;

  always @(negedge clk) begin
    bit          e_rdy;
    logic [63:0] e_pc;
    logic [63:0] e_tg;
    bit          e_tk;
    bp_update_t  e;
    if (!rst_n) begin
      m_q.delete();
      m_out   = '0;
      m_vld   = 0;
      m_flush = 0;
      m_ren   = 0;
      m_idx   = 0;
    end
    e_rdy = m_ren && !m_flush && !flush_req && ((DEPTH - m_q.size()) >= NR);
    e_pc  = m_flush ? 64'(m_idx * 4) : (m_vld ? m_out.pc : 64'd0);
    e_tk  = !m_flush && m_vld && m_out.taken;
    e_tg  = (!m_flush && m_vld) ? m_out.target : 64'd0;
    chk("model_ready", 64'(req_ready), {62'd0, e_rdy, e_rdy});
    chk("model_flags", {60'd0, flush_busy, upd_valid, upd_clear, upd_taken},
        {60'd0, m_flush, (m_flush || m_vld), m_flush, e_tk});
    chk("model_pc", upd_pc, e_pc);
    chk("model_target", upd_target, e_tg);
    if (rst_n) begin
      if (upd_valid && !upd_clear) obs_q.push_back(upd_pc);
      if (upd_clear) clr_cnt++;
      m_ren = 1;
      if (!m_flush) begin
        if (flush_req) begin
          m_q.delete();
          m_flush = 1;
          m_idx   = 0;
          m_vld   = 0;
        end else begin
          if (m_q.size() > 0) begin
            m_out = m_q.pop_front();
            m_vld = 1;
          end else begin
            m_vld = 0;
          end
          if (e_rdy) begin
            for (int i = 0; i < NR; i++) begin
              if (req_valid[i]) begin
                e.pc     = req_pc[64*i +: 64];
                e.taken  = req_taken[i];
                e.target = req_target[64*i +: 64];
                m_q.push_back(e);
              end
            end
          end
        end
      end else begin
        if (flush_req) m_idx = 0;
        else if (m_idx == TBL - 1) begin
          m_flush = 0;
          m_vld   = 0;
        end else m_idx++;
      end
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [1:0]  v;
    logic [63:0] pc0, pc1;
    logic [1:0]  tk;
    logic [63:0] tg0, tg1;
    int          n;
    logic [63:0] e_pc0; logic e_tk0; logic [63:0] e_tg0;
    logic [63:0] e_pc1; logic e_tk1; logic [63:0] e_tg1;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int k;
    int guard;
    bit accepted;
    bit saw_stall;

    vecs[0] = '{2'b01, 64'h1000, 64'h0, 2'b01, 64'h2000, 64'h0, 1,
                64'h1000, 1'b1, 64'h2000, 64'h0, 1'b0, 64'h0};
    vecs[1] = '{2'b10, 64'h0, 64'h8000_0000_0040, 2'b00, 64'h0, 64'h8000_0000_0100, 1,
                64'h8000_0000_0040, 1'b0, 64'h8000_0000_0100, 64'h0, 1'b0, 64'h0};
    vecs[2] = '{2'b11, 64'h100, 64'h200, 2'b10, 64'h500, 64'h600, 2,
                64'h100, 1'b0, 64'h500, 64'h200, 1'b1, 64'h600};
    vecs[3] = '{2'b11, 64'hFFFF_FFFF_FFFF_FFFC, 64'h4, 2'b11, 64'h0, 64'hFFFF_FFFF_FFFF_FFF0, 2,
                64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'h0, 64'h4, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0};
    vecs[4] = '{2'b00, 64'h700, 64'h800, 2'b11, 64'h900, 64'hA00, 0,
                64'h0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0};

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_flags", {60'd0, flush_busy, upd_valid, upd_clear, upd_taken}, 64'd0);
    chk("rst_pc", upd_pc, 64'd0);
    chk("rst_target", upd_target, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 64'(req_ready), 64'd3);

    // Table-driven single/pair transactions (handshake t -> output t+2)
    foreach (vecs[j]) begin
      req_valid  = vecs[j].v;
      req_pc     = {vecs[j].pc1, vecs[j].pc0};
      req_taken  = vecs[j].tk;
      req_target = {vecs[j].tg1, vecs[j].tg0};
      tick();
      req_valid = '0;
      chk("vec_t1_valid", 64'(upd_valid), 64'd0);
      tick();
      chk("vec_t2_valid", 64'(upd_valid), 64'(vecs[j].n >= 1));
      chk("vec_t2_pc", upd_pc, vecs[j].e_pc0);
      chk("vec_t2_taken", 64'(upd_taken), 64'(vecs[j].e_tk0));
      chk("vec_t2_target", upd_target, vecs[j].e_tg0);
      chk("vec_t2_clear", 64'(upd_clear), 64'd0);
      tick();
      chk("vec_t3_valid", 64'(upd_valid), 64'(vecs[j].n == 2));
      chk("vec_t3_pc", upd_pc, vecs[j].e_pc1);
      chk("vec_t3_taken", 64'(upd_taken), 64'(vecs[j].e_tk1));
      chk("vec_t3_target", upd_target, vecs[j].e_tg1);
      tick();
      chk("vec_t4_valid", 64'(upd_valid), 64'd0);
    end

    // Saturation: both requesters hold until 12 updates are accepted
    obs_q.delete();
    saw_stall = 0;
    k = 0;
    guard = 0;
    while (k < 12 && guard < 100) begin
      req_valid  = 2'b11;
      req_pc     = {64'(32'h4000 + 16 * (k + 1)), 64'(32'h4000 + 16 * k)};
      req_taken  = 2'b01;
      req_target = {64'h9000 + 64'(k), 64'h9000 + 64'(k)};
      @(negedge clk);
      accepted = req_ready[0];
      if (!req_ready[0]) saw_stall = 1;
      @(posedge clk);
      #1;
      if (accepted) k += 2;
      guard++;
    end
    req_valid = '0;
    chk("sat_accepted", 64'(k), 64'd12);
    repeat (10) tick();
    chk("sat_stalled", 64'(saw_stall), 64'd1);
    chk("sat_count", 64'(obs_q.size()), 64'd12);
    for (int j = 0; j < 12 && j < obs_q.size(); j++)
      chk("sat_order", obs_q[j], 64'(32'h4000 + 16 * j));

    // Flush with 3 entries still queued
    obs_q.delete();
    req_valid = 2'b11;
    req_pc    = {64'h5010, 64'h5000};
    tick();
    req_pc    = {64'h5030, 64'h5020};
    tick();
    req_valid = '0;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int i = 0; i < TBL; i++) begin
      chk("fl_clear", {62'd0, upd_valid, upd_clear}, 64'd3);
      chk("fl_pc", upd_pc, 64'(i * 4));
      chk("fl_busy", 64'(flush_busy), 64'd1);
      chk("fl_ready", 64'(req_ready), 64'd0);
      tick();
    end
    chk("fl_end_flags", {61'd0, flush_busy, upd_valid, upd_clear}, 64'd0);
    chk("fl_end_ready", 64'(req_ready), 64'd3);
    repeat (3) tick();
    chk("fl_discard_count", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() > 0) chk("fl_presented", obs_q[0], 64'h5000);

    // Flush restarted at idx 100
    clr_cnt = 0;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (100) tick();
    chk("rs_pc100", upd_pc, 64'd400);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    chk("rs_restart_pc", upd_pc, 64'd0);
    chk("rs_restart_clear", 64'(upd_clear), 64'd1);
    guard = 0;
    while (flush_busy && guard < 400) begin
      tick();
      guard++;
    end
    chk("rs_total_clears", 64'(clr_cnt), 64'd357);

    // Asynchronous reset in the middle of a walk
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (50) tick();
    chk("ar_pc50", upd_pc, 64'd200);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_flags", {60'd0, flush_busy, upd_valid, upd_clear, upd_taken}, 64'd0);
    chk("ar_pc", upd_pc, 64'd0);
    chk("ar_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("ar_post_ready", 64'(req_ready), 64'd3);
    chk("ar_post_busy", 64'(flush_busy), 64'd0);
    clr_cnt = 0;
    repeat (5) tick();
    chk("ar_no_clear", 64'(clr_cnt), 64'd0);

    // Random traffic and occasional flushes against the model
    for (int c = 0; c < 3000; c++) begin
      req_valid  = 2'($urandom_range(0, 3));
      req_pc     = {$urandom(), $urandom(), $urandom(), $urandom()};
      req_taken  = 2'($urandom_range(0, 3));
      req_target = {$urandom(), $urandom(), $urandom(), $urandom()};
      flush_req  = ($urandom_range(0, 299) == 0);
      tick();
    end
    req_valid = '0;
    flush_req = 1'b0;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
